// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60) and the decoder lock-FSM encoding.
// Both the timing decoder and any VGA sync generator draw from this package.
package vga_timing_pkg;

  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_H_ACTIVE = 640;

  localparam int VGA_V_TOTAL  = 525;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } vga_state_e;

endpackage

// File: rtl/vga_edge_detect.sv
// Rising-edge detector: one previous-sample register and a combinational
// rise strobe that is high in the cycle the input first reads 1.
module vga_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // Remember last cycle's level of the sync input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/vga_timing_decoder.sv
// VGA timing decoder: measures incoming hs/vs against the expected timing,
// locks after LOCK_FRAMES consecutive good frames, and produces registered
// counters, visible-pixel strobe and pixel coordinates.
module vga_timing_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BACK      = VGA_H_BACK,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BACK      = VGA_V_BACK,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs,
  input  logic       vs,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       locked,
  output logic [7:0] err_cnt
);

  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [9:0]  H_START   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  H_END     = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_START   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_END     = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [7:0]  LOCK_N    = 8'(LOCK_FRAMES);

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       hs_rise, vs_rise;
  vga_state_e state_q, state_d;
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, x_q, x_d, y_q, y_d;
  logic [7:0] gcnt_q, gcnt_d, err_q, err_d;
  logic       pend_q, pend_d, first_q, first_d, bad_seen_q, bad_seen_d;
  logic       de_q, de_d, locked_q, locked_d;
  logic       frame_start, line_bad, frame_good;

  vga_edge_detect u_hs_edge (.clk(clk), .rst(rst), .sig_i(hs), .rise_o(hs_rise));
  vga_edge_detect u_vs_edge (.clk(clk), .rst(rst), .sig_i(vs), .rise_o(vs_rise));

  // Counters, pending-frame flag and line/frame measurement.
  always_comb begin
    frame_start = hs_rise & (pend_q | vs_rise);
    // The first line after reset or after dropping to SEARCH has no valid start.
    line_bad    = hs_rise & ~first_q & (({1'b0, h_cnt_q} + 11'd1) != H_TOTAL_W);
    frame_good  = (({1'b0, v_cnt_q} + 11'd1) == V_TOTAL_W) & ~bad_seen_q & ~line_bad;
    h_cnt_d     = hs_rise ? 10'd0 : sat_inc10(h_cnt_q);
    v_cnt_d     = v_cnt_q;
    if (frame_start)  v_cnt_d = 10'd0;
    else if (hs_rise) v_cnt_d = sat_inc10(v_cnt_q);
    pend_d      = frame_start ? 1'b0 : (pend_q | vs_rise);
    bad_seen_d  = frame_start ? 1'b0 : (bad_seen_q | line_bad);
  end

  // Lock FSM: next state, good-frame counter, error counter, exemption flag.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    err_d   = err_q;
    first_d = hs_rise ? 1'b0 : first_q;
    case (state_q)
      ST_SEARCH: begin
        if (frame_start) begin
          state_d = ST_MEASURE;
          gcnt_d  = 8'd0;
        end
      end
      ST_MEASURE: begin
        if (frame_start) begin
          if (frame_good) begin
            gcnt_d = gcnt_q + 8'd1;
            if (gcnt_q + 8'd1 == LOCK_N) state_d = ST_LOCKED;
          end else begin
            gcnt_d = 8'd0;
          end
        end
      end
      ST_LOCKED: begin
        if (line_bad || (frame_start && !frame_good)) begin
          state_d = ST_SEARCH;
          err_d   = sat_inc8(err_q);
          first_d = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Visible-region decode from next-cycle counters so outputs stay registered.
  always_comb begin
    locked_d = (state_d == ST_LOCKED);
    de_d     = locked_d && (h_cnt_d >= H_START) && (h_cnt_d < H_END) &&
               (v_cnt_d >= V_START) && (v_cnt_d < V_END);
    x_d      = 10'd0;
    y_d      = 10'd0;
    if (de_d) begin
      x_d = h_cnt_d - H_START;
      y_d = v_cnt_d - V_START;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_SEARCH;
    else     state_q <= state_d;
  end

  // Counter, flag and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q    <= 10'd0;
      v_cnt_q    <= 10'd0;
      pend_q     <= 1'b0;
      first_q    <= 1'b1;
      bad_seen_q <= 1'b0;
      gcnt_q     <= 8'd0;
      err_q      <= 8'd0;
      de_q       <= 1'b0;
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      locked_q   <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      pend_q     <= pend_d;
      first_q    <= first_d;
      bad_seen_q <= bad_seen_d;
      gcnt_q     <= gcnt_d;
      err_q      <= err_d;
      de_q       <= de_d;
      x_q        <= x_d;
      y_q        <= y_d;
      locked_q   <= locked_d;
    end
  end

  assign h_cnt   = h_cnt_q;
  assign v_cnt   = v_cnt_q;
  assign de      = de_q;
  assign x       = x_q;
  assign y       = y_q;
  assign locked  = locked_q;
  assign err_cnt = err_q;

endmodule
